// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared constants and types
// for the truth-table sweep sequencer.
package tt_sweep_pkg;

  localparam int NIN     = 7;
  localparam int NPTS    = 1 << NIN;
  localparam int LAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } tt_state_e;

  typedef logic [NPTS-1:0] tt_vec_t;
  typedef logic [NIN-1:0]  tt_idx_t;

  function automatic logic [7:0] inc_ones(
    input logic [7:0] n,
    input logic       b
  );
    return n + {7'd0, b};
  endfunction

endpackage

// File: rtl/tt_capture_pipe.sv
// tt_capture_pipe: LAT-deep delay line of
// {valid, index} aligning issue with f_in.
module tt_capture_pipe
  import tt_sweep_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush_i,
  input  logic    vld_i,
  input  tt_idx_t idx_i,
  output logic    vld_o,
  output tt_idx_t idx_o
);

  if (LAT == 0) begin : g_thru
    logic unused_thru;
    assign unused_thru = ^{clk, rst_n, flush_i};
    assign vld_o = vld_i;
    assign idx_o = idx_i;
  end else begin : g_pipe
    logic [LAT-1:0] v_q;
    tt_idx_t        ix_q [LAT];

    // shift issue tags; flush drops in-flight ones
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int k = 0; k < LAT; k++) begin
          ix_q[k] <= '0;
        end
      end else if (flush_i) begin
        v_q <= '0;
        for (int k = 0; k < LAT; k++) begin
          ix_q[k] <= '0;
        end
      end else begin
        v_q[0]  <= vld_i;
        ix_q[0] <= idx_i;
        for (int k = 1; k < LAT; k++) begin
          v_q[k]  <= v_q[k-1];
          ix_q[k] <= ix_q[k-1];
        end
      end
    end

    assign vld_o = v_q[LAT-1];
    assign idx_o = ix_q[LAT-1];
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps all input vectors of a
// 7-input network and captures its truth table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int      LAT    = 0,
  parameter tt_vec_t EXP_TT =
    128'hfeeaeaa8fee8e880fee8e880eaa8a880
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [NIN-1:0]  x_vec,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            valid,
  output logic [NPTS-1:0] tt,
  output logic [7:0]      ones,
  output logic            match
);

  localparam logic [2:0] LAT_M1 =
    3'((LAT > 0) ? LAT - 1 : 0);
  localparam tt_idx_t LAST_IDX =
    tt_idx_t'(NPTS - 1);

  tt_state_e  state_q;
  tt_idx_t    x_q;
  logic [2:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       valid_q;
  logic       match_q;
  tt_vec_t    tt_q;
  logic [7:0] ones_q;

  logic    accept;
  logic    issue;
  logic    active;
  logic    flush;
  logic    cap_v;
  tt_idx_t cap_idx;
  logic    cap;

  assign accept = (state_q == IDLE) && start;
  assign issue  = (state_q == DRIVE);
  assign active = (state_q == DRIVE) ||
                  (state_q == DRAIN);
  assign flush  = active && abort;

  tt_capture_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .vld_i   (issue),
    .idx_i   (x_q),
    .vld_o   (cap_v),
    .idx_o   (cap_idx)
  );

  assign cap = cap_v && active;

  // sequencer: issue, drain, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            x_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            match_q <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (x_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= (LAT > 0) ? DRAIN : DONE;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == LAT_M1) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          match_q <= (tt_q == EXP_TT);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // truth-table and popcount capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q   <= '0;
      ones_q <= '0;
    end else if (accept) begin
      tt_q   <= '0;
      ones_q <= '0;
    end else if (cap) begin
      tt_q[cap_idx] <= f_in;
      ones_q <= inc_ones(ones_q, f_in);
    end
  end

  assign x_vec = x_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign tt    = tt_q;
  assign ones  = ones_q;
  assign match = match_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: scoreboard bench driving
// LAT=0 and LAT=3 sweepers with one stimulus.
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    logic         match;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [6:0]   x0, x3;
  logic         f0, f3;
  logic         busy0, busy3;
  logic         done0, done3;
  logic         valid0, valid3;
  logic         match0, match3;
  logic [127:0] tt0, tt3;
  logic [7:0]   ones0, ones3;

  logic [127:0] exp_tt =
    128'hfeeaeaa8fee8e880fee8e880eaa8a880;
  logic [127:0] rnd_tt = '0;
  int           mode = 0;

  logic [2:0][6:0] xd = '0;
  logic pd0 = 1'b0;
  logic pd3 = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q3[$];

  tt_sweep_ctrl #(.LAT(0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .x_vec (x0),
    .f_in  (f0),
    .busy  (busy0),
    .done  (done0),
    .valid (valid0),
    .tt    (tt0),
    .ones  (ones0),
    .match (match0)
  );

  tt_sweep_ctrl #(.LAT(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .x_vec (x3),
    .f_in  (f3),
    .busy  (busy3),
    .done  (done3),
    .valid (valid3),
    .tt    (tt3),
    .ones  (ones3),
    .match (match3)
  );

  always #5 clk = ~clk;

  // network under test: m selects the function
  function automatic logic model_f(
    input int           m,
    input logic [6:0]   x,
    input logic [127:0] r,
    input logic [127:0] ex
  );
    case (m)
      0:       return ex[x];
      1:       return 1'b1;
      2:       return x[6];
      default: return r[x];
    endcase
  endfunction

  assign f0 = model_f(mode, x0, rnd_tt, exp_tt);
  assign f3 = model_f(mode, xd[2], rnd_tt, exp_tt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    xd  <= {xd[1:0], x3};
  end

  task automatic chk(
    input string        nm,
    input logic [159:0] got,
    input logic [159:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, want);
    end
  endtask

  task automatic cmp_done(
    input string        nm,
    input exp_t         e,
    input logic [127:0] t,
    input logic [7:0]   o,
    input logic         m,
    input logic         v
  );
    chk({nm, " tt"}, 160'(t), 160'(e.tt));
    chk({nm, " ones"}, 160'(o), 160'(e.ones));
    chk({nm, " match"}, 160'(m), 160'(e.match));
    chk({nm, " valid"}, 160'(v), 160'd1);
    chk({nm, " latency"}, 160'(cyc), 160'(e.due));
  endtask

  // monitor: pop expectation on every done
  always @(negedge clk) begin
    if (rst_n && done0) begin
      chk("u0 done width", 160'(pd0), 160'd0);
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0 unexpected done at %0d",
                 cyc);
      end else begin
        cmp_done("u0", q0.pop_front(),
                 tt0, ones0, match0, valid0);
      end
    end
    if (rst_n && done3) begin
      chk("u3 done width", 160'(pd3), 160'd0);
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u3 unexpected done at %0d",
                 cyc);
      end else begin
        cmp_done("u3", q3.pop_front(),
                 tt3, ones3, match3, valid3);
      end
    end
    pd0 <= rst_n && done0;
    pd3 <= rst_n && done3;
  end

  task automatic sweep(
    input int m,
    input bit push,
    input bit glitch
  );
    exp_t e;
    @(negedge clk);
    mode = m;
    if (m == 3) begin
      rnd_tt = {$urandom(), $urandom(),
                $urandom(), $urandom()};
    end
    e.tt = '0;
    for (int i = 0; i < 128; i++) begin
      e.tt[i] = model_f(m, 7'(i), rnd_tt, exp_tt);
    end
    e.ones  = 8'($countones(e.tt));
    e.match = (e.tt == exp_tt);
    if (push) begin
      e.due = cyc + 130;
      q0.push_back(e);
      e.due = cyc + 133;
      q3.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch) begin
      for (int g = 0; g < 3; g++) begin
        repeat ($urandom_range(5, 35)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() + q3.size()) != 0 &&
           n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL sweep timeout: %0d pending",
               q0.size() + q3.size());
      q0.delete();
      q3.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " u0 ctl"},
        160'({x0, busy0, done0, valid0,
              match0, ones0}), 160'd0);
    chk({nm, " u0 tt"}, 160'(tt0), 160'd0);
    chk({nm, " u3 ctl"},
        160'({x3, busy3, done3, valid3,
              match3, ones3}), 160'd0);
    chk({nm, " u3 tt"}, 160'(tt3), 160'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    sweep(0, 1'b1, 1'b0);
    wait_idle();
    sweep(0, 1'b1, 1'b1);
    wait_idle();
    sweep(1, 1'b1, 1'b0);
    wait_idle();
    sweep(2, 1'b1, 1'b1);
    wait_idle();
    for (int r = 0; r < 3; r++) begin
      sweep(3, 1'b1, r[0]);
      wait_idle();
    end

    sweep(0, 1'b0, 1'b0);
    n = 0;
    while (x0 != 7'd50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach 50", 160'(x0), 160'd50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort u0 busy", 160'(busy0), 160'd0);
    chk("abort u3 busy", 160'(busy3), 160'd0);
    chk("abort u0 valid", 160'(valid0), 160'd0);
    chk("abort u3 valid", 160'(valid3), 160'd0);
    repeat (150) @(negedge clk);
    sweep(0, 1'b1, 1'b0);
    wait_idle();

    sweep(0, 1'b0, 1'b0);
    repeat (128) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sweep(3, 1'b1, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queues drained",
        160'(q0.size() + q3.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
